// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle control unit for the accumulator CPU core.
// Decodes the 6-bit opcode into data-path selects. It also holds the
// registered zero flag, the return-address stack for JAL/RET, and the
// valid/ready I/O handshakes. It owns the PC load enable.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | decode one instruction per cycle
// WAIT_OUT | output transfer pending on lat_idx, PC frozen until out_ready
// WAIT_IN  | input transfer pending on lat_idx, PC frozen until in_valid
// HALT     | sticky stop, PC frozen, left only by reset
module control_unit_mc #(
    parameter int PCW         = 10,
    parameter int STACK_DEPTH = 4,
    parameter int NPORTS      = 4,
    localparam int PSW        = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    input  logic [PSW-1:0]    port_idx,
    input  logic              z,
    input  logic [PCW-1:0]    pc_plus1,
    output logic [2:0]        op,
    output logic              s_inc,
    output logic              s_ret,
    output logic              pc_en,
    output logic              we3,
    output logic              s_inm,
    output logic              s_epe,
    output logic              s_sps,
    output logic [PCW-1:0]    stack_top,
    output logic [NPORTS-1:0] out_valid,
    input  logic [NPORTS-1:0] out_ready,
    output logic [NPORTS-1:0] in_ready,
    input  logic [NPORTS-1:0] in_valid,
    output logic              zflag,
    output logic              stack_err,
    output logic              halted
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [PSW:0]        NP_EXT  = (PSW + 1)'(NPORTS);
    localparam logic [PSW-1:0]      NP_MAX  = PSW'(NPORTS - 1);
    localparam logic [SPW-1:0]      SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [SPW-1:0]      SP_ONE  = SPW'(1);
    localparam logic [NPORTS-1:0]   CH_ONE  = NPORTS'(1);

    localparam logic [5:0] OP_JMP  = 6'b001001;
    localparam logic [5:0] OP_JZ   = 6'b101001;
    localparam logic [5:0] OP_JNZ  = 6'b011001;
    localparam logic [5:0] OP_JAL  = 6'b111001;
    localparam logic [5:0] OP_RET  = 6'b001010;
    localparam logic [5:0] OP_OUTR = 6'b011010;
    localparam logic [5:0] OP_OUTI = 6'b101010;
    localparam logic [5:0] OP_IN   = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_OUT = 2'd1,
        WAIT_IN  = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             zflag_q;
    logic             stack_err_q;
    logic [SPW-1:0]   sp;
    logic [PCW-1:0]   stack_mem [STACK_DEPTH];
    logic [PSW-1:0]   lat_idx;
    logic             lat_sps;

    logic [PSW-1:0]   port_sel;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic [PCW-1:0]   top_raw;
    logic             sp_empty;
    logic             sp_full;

    logic             load_z;
    logic             do_push;
    logic             do_pop;
    logic             set_err;
    logic             latch;
    logic             sps_dec;

    assign op = opcode[2:0];

    assign sp_empty = (sp == '0);
    assign sp_full  = (sp == SP_FULL);
    assign top_idx  = AW'(sp - SP_ONE);
    assign push_idx = AW'(sp);
    assign top_raw  = sp_empty ? '0 : stack_mem[top_idx];

    // Registered status is forced low while reset is held.
    assign stack_top = reset ? '0 : top_raw;
    assign zflag     = zflag_q & ~reset;
    assign stack_err = stack_err_q & ~reset;
    assign halted    = (state == HALT) & ~reset;

    // Out-of-range channel numbers clamp to the highest channel; with a
    // power-of-two NPORTS the field never exceeds the range.
    always_comb begin
        if ({1'b0, port_idx} >= NP_EXT) begin
            port_sel = NP_MAX;
        end else begin
            port_sel = port_idx;
        end
    end

    // Decode: data-path selects plus the strobes the register block applies.
    always_comb begin
        s_inc     = 1'b1;
        s_ret     = 1'b0;
        pc_en     = 1'b0;
        we3       = 1'b0;
        s_inm     = 1'b0;
        s_epe     = 1'b0;
        s_sps     = 1'b0;
        out_valid = '0;
        in_ready  = '0;
        state_nxt = state;
        load_z    = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_err   = 1'b0;
        latch     = 1'b0;
        sps_dec   = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    pc_en = 1'b1;
                    if (!opcode[3]) begin
                        we3    = 1'b1;
                        load_z = 1'b1;
                    end else if (opcode[2:0] == 3'b000) begin
                        we3   = 1'b1;
                        s_inm = 1'b1;
                    end else begin
                        case (opcode)
                            OP_JMP: s_inc = 1'b0;
                            OP_JZ:  s_inc = ~zflag_q;
                            OP_JNZ: s_inc = zflag_q;
                            OP_JAL: begin
                                // The jump is taken even when the push is dropped.
                                s_inc = 1'b0;
                                if (sp_full) begin
                                    set_err = 1'b1;
                                end else begin
                                    do_push = 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (sp_empty) begin
                                    set_err = 1'b1;
                                end else begin
                                    s_ret  = 1'b1;
                                    do_pop = 1'b1;
                                end
                            end
                            OP_OUTR, OP_OUTI: begin
                                pc_en     = 1'b0;
                                latch     = 1'b1;
                                sps_dec   = (opcode == OP_OUTR);
                                s_sps     = sps_dec;
                                state_nxt = WAIT_OUT;
                            end
                            OP_IN: begin
                                pc_en     = 1'b0;
                                latch     = 1'b1;
                                state_nxt = WAIT_IN;
                            end
                            OP_HALT: begin
                                pc_en     = 1'b0;
                                state_nxt = HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                WAIT_OUT: begin
                    out_valid = CH_ONE << lat_idx;
                    s_sps     = lat_sps;
                    if (out_ready[lat_idx]) begin
                        pc_en     = 1'b1;
                        state_nxt = RUN;
                    end
                end
                WAIT_IN: begin
                    in_ready = CH_ONE << lat_idx;
                    if (in_valid[lat_idx]) begin
                        we3       = 1'b1;
                        s_epe     = 1'b1;
                        pc_en     = 1'b1;
                        state_nxt = RUN;
                    end
                end
                HALT: ;
                default: state_nxt = RUN;
            endcase
        end
    end

    // State, zero flag, return stack, error flag and latched port fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            zflag_q     <= 1'b0;
            sp          <= '0;
            stack_err_q <= 1'b0;
            lat_idx     <= '0;
            lat_sps     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_z) begin
                zflag_q <= z;
            end
            if (do_push) begin
                stack_mem[push_idx] <= pc_plus1;
                sp                  <= sp + SP_ONE;
            end else if (do_pop) begin
                sp <= sp - SP_ONE;
            end
            if (set_err) begin
                stack_err_q <= 1'b1;
            end
            if (latch) begin
                lat_idx <= port_sel;
                lat_sps <= sps_dec;
            end
        end
    end

endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: scoreboard bench for control_unit_mc. Each cycle the
// stimulus pushes its expected outputs; they are popped and compared on
// the falling edge, after the combinational decode has settled.
module tb_control_unit_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [1:0]  port_idx;
    logic        z;
    logic [9:0]  pc_plus1;
    logic [2:0]  op;
    logic        s_inc, s_ret, pc_en, we3, s_inm, s_epe, s_sps;
    logic [9:0]  stack_top;
    logic [3:0]  out_valid, out_ready, in_ready, in_valid;
    logic        zflag, stack_err, halted;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] OP_ALU  = 6'b000000;
    localparam logic [5:0] OP_LDI  = 6'b001000;
    localparam logic [5:0] OP_JMP  = 6'b001001;
    localparam logic [5:0] OP_JZ   = 6'b101001;
    localparam logic [5:0] OP_JNZ  = 6'b011001;
    localparam logic [5:0] OP_JAL  = 6'b111001;
    localparam logic [5:0] OP_RET  = 6'b001010;
    localparam logic [5:0] OP_OUTR = 6'b011010;
    localparam logic [5:0] OP_OUTI = 6'b101010;
    localparam logic [5:0] OP_IN   = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_NOP  = 6'b001011;

    localparam int SIG_INC = 0, SIG_RET = 1, SIG_PCEN = 2, SIG_WE3 = 3,
                   SIG_INM = 4, SIG_EPE = 5, SIG_SPS = 6, SIG_OV = 7,
                   SIG_IR = 8, SIG_HALT = 9, SIG_ZF = 10, SIG_ERR = 11,
                   SIG_TOP = 12, SIG_OP = 13;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    control_unit_mc dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .port_idx  (port_idx),
        .z         (z),
        .pc_plus1  (pc_plus1),
        .op        (op),
        .s_inc     (s_inc),
        .s_ret     (s_ret),
        .pc_en     (pc_en),
        .we3       (we3),
        .s_inm     (s_inm),
        .s_epe     (s_epe),
        .s_sps     (s_sps),
        .stack_top (stack_top),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .in_valid  (in_valid),
        .zflag     (zflag),
        .stack_err (stack_err),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            SIG_INC:  return {31'b0, s_inc};
            SIG_RET:  return {31'b0, s_ret};
            SIG_PCEN: return {31'b0, pc_en};
            SIG_WE3:  return {31'b0, we3};
            SIG_INM:  return {31'b0, s_inm};
            SIG_EPE:  return {31'b0, s_epe};
            SIG_SPS:  return {31'b0, s_sps};
            SIG_OV:   return {28'b0, out_valid};
            SIG_IR:   return {28'b0, in_ready};
            SIG_HALT: return {31'b0, halted};
            SIG_ZF:   return {31'b0, zflag};
            SIG_ERR:  return {31'b0, stack_err};
            SIG_TOP:  return {22'b0, stack_top};
            SIG_OP:   return {29'b0, op};
            default:  return 32'hffff_ffff;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ex(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drv(input logic [5:0] opc, input logic [1:0] pidx, input logic zz,
                       input logic [9:0] pc1, input logic [3:0] ordy, input logic [3:0] ival);
        opcode    = opc;
        port_idx  = pidx;
        z         = zz;
        pc_plus1  = pc1;
        out_ready = ordy;
        in_valid  = ival;
    endtask

    // Compare everything queued for this cycle, then advance one clock.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sig), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(OP_ALU, 2'd0, 1'b1, 10'd0, 4'hf, 4'hf);
        // Reset state: everything low except s_inc.
        ex("rst_sinc", SIG_INC, 1);
        ex("rst_pcen", SIG_PCEN, 0);
        ex("rst_we3", SIG_WE3, 0);
        ex("rst_ov", SIG_OV, 0);
        ex("rst_halt", SIG_HALT, 0);
        tick();
        ex("rst_zf", SIG_ZF, 0);
        ex("rst_err", SIG_ERR, 0);
        ex("rst_top", SIG_TOP, 0);
        tick();
        reset = 1'b0;

        // Zero flag and conditional jumps.
        drv(OP_ALU | 6'd5, 2'd0, 1'b1, 10'd0, 4'h0, 4'h0);
        ex("alu_we3", SIG_WE3, 1);
        ex("alu_pcen", SIG_PCEN, 1);
        ex("alu_op", SIG_OP, 5);
        tick();
        drv(OP_LDI, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("ldi_we3", SIG_WE3, 1);
        ex("ldi_inm", SIG_INM, 1);
        ex("ldi_zf", SIG_ZF, 1);
        tick();
        drv(OP_JZ, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("jz_taken", SIG_INC, 0);
        ex("jz_zf", SIG_ZF, 1);
        tick();
        drv(OP_JNZ, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("jnz_not", SIG_INC, 1);
        tick();
        drv(OP_ALU, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        tick();
        drv(OP_JZ, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("jz_not", SIG_INC, 1);
        ex("jz_zf0", SIG_ZF, 0);
        tick();
        drv(OP_JNZ, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("jnz_taken", SIG_INC, 0);
        tick();
        drv(OP_JMP, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("jmp_sinc", SIG_INC, 0);
        ex("jmp_pcen", SIG_PCEN, 1);
        tick();
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("nop_we3", SIG_WE3, 0);
        ex("nop_sinc", SIG_INC, 1);
        ex("nop_pcen", SIG_PCEN, 1);
        tick();

        // Return stack: four pushes fit, the fifth overflows.
        for (int i = 1; i <= 5; i++) begin
            drv(OP_JAL, 2'd0, 1'b0, 10'(i), 4'h0, 4'h0);
            ex("jal_sinc", SIG_INC, 0);
            ex("jal_pcen", SIG_PCEN, 1);
            ex("jal_top", SIG_TOP, i - 1);
            ex("jal_err", SIG_ERR, 0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drv(OP_RET, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
            ex("ret_sret", SIG_RET, 1);
            ex("ret_top", SIG_TOP, 4 - k);
            ex("ret_err", SIG_ERR, 1);
            tick();
        end
        drv(OP_RET, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("ret_empty_sret", SIG_RET, 0);
        ex("ret_empty_sinc", SIG_INC, 1);
        ex("ret_empty_top", SIG_TOP, 0);
        tick();
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("err_sticky", SIG_ERR, 1);
        tick();

        // Output from register on channel 2, partner stalls three cycles.
        drv(OP_OUTR, 2'd2, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("outr_dec_pcen", SIG_PCEN, 0);
        ex("outr_dec_ov", SIG_OV, 0);
        tick();
        for (int w = 0; w < 3; w++) begin
            drv(OP_JAL, 2'd0, 1'b0, 10'd9, 4'b1011, 4'h0);
            ex("outr_wait_ov", SIG_OV, 4'b0100);
            ex("outr_wait_pcen", SIG_PCEN, 0);
            ex("outr_wait_sps", SIG_SPS, 1);
            tick();
        end
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'b0100, 4'h0);
        ex("outr_done_ov", SIG_OV, 4'b0100);
        ex("outr_done_pcen", SIG_PCEN, 1);
        ex("outr_done_sinc", SIG_INC, 1);
        ex("outr_done_sps", SIG_SPS, 1);
        ex("outr_no_push", SIG_TOP, 0);
        tick();
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'hf, 4'h0);
        ex("outr_after_ov", SIG_OV, 0);
        ex("outr_after_pcen", SIG_PCEN, 1);
        tick();

        // Output immediate on channel 3 with the partner already ready.
        drv(OP_OUTI, 2'd3, 1'b0, 10'd0, 4'b1000, 4'h0);
        ex("outi_dec_pcen", SIG_PCEN, 0);
        tick();
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'b1000, 4'h0);
        ex("outi_ov", SIG_OV, 4'b1000);
        ex("outi_sps", SIG_SPS, 0);
        ex("outi_pcen", SIG_PCEN, 1);
        tick();

        // Input on channel 1; channel 0 valid must be ignored.
        drv(OP_IN, 2'd1, 1'b0, 10'd0, 4'h0, 4'b0001);
        ex("in_dec_pcen", SIG_PCEN, 0);
        ex("in_dec_ir", SIG_IR, 0);
        tick();
        for (int w = 0; w < 2; w++) begin
            drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'h0, 4'b0001);
            ex("in_wait_ir", SIG_IR, 4'b0010);
            ex("in_wait_we3", SIG_WE3, 0);
            ex("in_wait_epe", SIG_EPE, 0);
            ex("in_wait_pcen", SIG_PCEN, 0);
            tick();
        end
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'h0, 4'b0011);
        ex("in_done_ir", SIG_IR, 4'b0010);
        ex("in_done_we3", SIG_WE3, 1);
        ex("in_done_epe", SIG_EPE, 1);
        ex("in_done_pcen", SIG_PCEN, 1);
        tick();
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("in_after_ir", SIG_IR, 0);
        ex("in_after_we3", SIG_WE3, 0);
        tick();

        // Sticky halt, released only by reset.
        drv(OP_HALT, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("halt_dec_pcen", SIG_PCEN, 0);
        ex("halt_dec_halted", SIG_HALT, 0);
        tick();
        for (int h = 0; h < 3; h++) begin
            drv((h == 0) ? OP_ALU : (h == 1) ? OP_JAL : OP_OUTR, 2'd0, 1'b1, 10'd3, 4'hf, 4'hf);
            ex("halt_halted", SIG_HALT, 1);
            ex("halt_pcen", SIG_PCEN, 0);
            ex("halt_we3", SIG_WE3, 0);
            ex("halt_ov", SIG_OV, 0);
            tick();
        end
        reset = 1'b1;
        ex("halt_rst_halted", SIG_HALT, 0);
        ex("halt_rst_sinc", SIG_INC, 1);
        tick();
        reset = 1'b0;
        drv(OP_ALU, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("unhalt_halted", SIG_HALT, 0);
        ex("unhalt_pcen", SIG_PCEN, 1);
        ex("unhalt_we3", SIG_WE3, 1);
        tick();

        // Build up state, then reset in the middle of an output wait.
        drv(OP_RET, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        tick();
        drv(OP_ALU, 2'd0, 1'b1, 10'd0, 4'h0, 4'h0);
        tick();
        drv(OP_JAL, 2'd0, 1'b0, 10'd7, 4'h0, 4'h0);
        ex("pre_err", SIG_ERR, 1);
        ex("pre_zf", SIG_ZF, 1);
        tick();
        drv(OP_OUTR, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("pre_top", SIG_TOP, 7);
        tick();
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("wait_ov0", SIG_OV, 4'b0001);
        tick();
        reset = 1'b1;
        ex("rstw_ov", SIG_OV, 0);
        ex("rstw_pcen", SIG_PCEN, 0);
        ex("rstw_sinc", SIG_INC, 1);
        ex("rstw_we3", SIG_WE3, 0);
        tick();
        ex("rstw_zf", SIG_ZF, 0);
        ex("rstw_err", SIG_ERR, 0);
        ex("rstw_sinc2", SIG_INC, 1);
        tick();
        reset = 1'b0;
        drv(OP_RET, 2'd0, 1'b0, 10'd0, 4'h1, 4'h0);
        ex("post_top", SIG_TOP, 0);
        ex("post_sret", SIG_RET, 0);
        ex("post_zf", SIG_ZF, 0);
        ex("post_ov", SIG_OV, 0);
        ex("post_pcen", SIG_PCEN, 1);
        tick();
        drv(OP_NOP, 2'd0, 1'b0, 10'd0, 4'h0, 4'h0);
        ex("post_err", SIG_ERR, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
